// File: rtl/input_fm_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : input_fm_pingpong
// Purpose  : Two-page input feature-map tile buffer with NB banks and NB read
//            ports. One page loads from the input FIFO while the other is read.
// Revision : 1.0
// ============================================================================
module input_fm_pingpong #(
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int NB    = 4,
    parameter int DEPTH = 4096,
    parameter int SW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 syn_rst,
    input  logic [AW-1:0]        cfg_slice_size,
    input  logic [SW-1:0]        cfg_slice_num,
    input  logic                 load_start,
    output logic                 load_ready,
    output logic                 load_done,
    output logic                 cfg_err,
    input  logic [DW-1:0]        fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    output logic                 rd_page_valid,
    input  logic                 rd_release,
    input  logic [NB*AW-1:0]     rd_addr,
    output logic [NB*DW-1:0]     rd_data
);

    localparam int c_BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = AW + SW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic            r_wr_page;
    logic            r_rd_page;
    logic [1:0]      r_page_valid;
    logic [AW-1:0]   r_size;
    logic [c_CW-1:0] r_total;
    logic [c_CW-1:0] r_pops;
    logic            r_wr_en;
    logic [AW-1:0]   r_off;
    logic [c_BW-1:0] r_bank;
    logic [c_CW-1:0] r_base;
    logic            r_cfg_err;

    logic [SW:0]     w_groups;
    logic [c_CW-1:0] w_need;
    logic [c_CW-1:0] w_total;
    logic            w_over;
    logic            w_start;
    logic            w_last_wr;
    logic            w_release;
    logic            w_off_wrap;
    logic [c_IW-1:0] w_wr_addr;

    // Slices are spread round-robin over banks, so a bank holds ceil(num/NB) slices.
    assign w_groups   = ({1'b0, cfg_slice_num} + (SW+1)'(NB - 1)) / (SW+1)'(NB);
    assign w_need     = c_CW'(w_groups) * c_CW'(cfg_slice_size);
    assign w_total    = c_CW'(cfg_slice_size) * c_CW'(cfg_slice_num);
    assign w_over     = w_need > c_CW'(DEPTH);

    assign load_ready = (r_state == c_IDLE) && !r_page_valid[r_wr_page];
    assign w_start    = load_start && load_ready;
    assign fifo_pop   = (r_state == c_LOAD) && !fifo_empty && (r_pops < r_total) && !syn_rst;
    // The write that follows the final pop is the only one seen with r_pops at total.
    assign w_last_wr  = r_wr_en && (r_pops == r_total);
    assign w_release  = rd_release && r_page_valid[r_rd_page];
    assign w_off_wrap = (r_off == r_size - AW'(1));
    assign w_wr_addr  = c_IW'(r_base + c_CW'(r_off));

    assign load_done     = (r_state == c_DONE);
    assign cfg_err       = r_cfg_err;
    assign rd_page_valid = r_page_valid[r_rd_page];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wr_page    <= 1'b0;
            r_rd_page    <= 1'b0;
            r_page_valid <= 2'b00;
            r_size       <= '0;
            r_total      <= '0;
            r_pops       <= '0;
            r_wr_en      <= 1'b0;
            r_off        <= '0;
            r_bank       <= '0;
            r_base       <= '0;
            r_cfg_err    <= 1'b0;
        end else if (syn_rst) begin
            r_state      <= c_IDLE;
            r_wr_page    <= 1'b0;
            r_rd_page    <= 1'b0;
            r_page_valid <= 2'b00;
            r_size       <= '0;
            r_total      <= '0;
            r_pops       <= '0;
            r_wr_en      <= 1'b0;
            r_off        <= '0;
            r_bank       <= '0;
            r_base       <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            r_wr_en   <= fifo_pop;
            if (fifo_pop) begin
                r_pops <= r_pops + c_CW'(1);
            end
            if (r_wr_en) begin
                if (w_off_wrap) begin
                    r_off <= '0;
                    if (r_bank == c_BW'(NB - 1)) begin
                        r_bank <= '0;
                        r_base <= r_base + c_CW'(r_size);
                    end else begin
                        r_bank <= r_bank + c_BW'(1);
                    end
                end else begin
                    r_off <= r_off + AW'(1);
                end
            end
            if (w_release) begin
                r_page_valid[r_rd_page] <= 1'b0;
                r_rd_page               <= ~r_rd_page;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        if (w_over) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_size  <= cfg_slice_size;
                            r_total <= w_total;
                            r_pops  <= '0;
                            r_off   <= '0;
                            r_bank  <= '0;
                            r_base  <= '0;
                            r_state <= (w_total == '0) ? c_DONE : c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_last_wr) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_page_valid[r_wr_page] <= 1'b1;
                    r_wr_page               <= ~r_wr_page;
                    r_state                 <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_bank
        logic [DW-1:0] r_mem0 [0:DEPTH-1];
        logic [DW-1:0] r_mem1 [0:DEPTH-1];
        logic [DW-1:0] r_q;
        logic [AW-1:0] w_ra;
        logic          w_ra_ok;
        logic          w_we;

        assign w_ra    = rd_addr[i*AW +: AW];
        assign w_ra_ok = {1'b0, w_ra} < (AW+1)'(DEPTH);
        assign w_we    = r_wr_en && !syn_rst && (r_bank == c_BW'(i));

        always_ff @(posedge clk) begin
            if (w_we) begin
                if (r_wr_page) begin
                    r_mem1[w_wr_addr] <= fifo_data;
                end else begin
                    r_mem0[w_wr_addr] <= fifo_data;
                end
            end
        end

        // Out-of-range addresses simply hold the previous read value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (syn_rst) begin
                r_q <= '0;
            end else if (w_ra_ok) begin
                r_q <= r_rd_page ? r_mem1[w_ra[c_IW-1:0]] : r_mem0[w_ra[c_IW-1:0]];
            end
        end

        assign rd_data[i*DW +: DW] = r_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_input_fm_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_fm_pingpong
// Purpose  : Directed self-checking bench for input_fm_pingpong.
// Revision : 1.0
// ============================================================================
module tb_input_fm_pingpong;

    localparam int c_AW    = 12;
    localparam int c_DW    = 32;
    localparam int c_NB    = 4;
    localparam int c_DEPTH = 64;
    localparam int c_SW    = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  syn_rst = 1'b0;
    logic [c_AW-1:0]       cfg_slice_size = '0;
    logic [c_SW-1:0]       cfg_slice_num = '0;
    logic                  load_start = 1'b0;
    logic                  load_ready;
    logic                  load_done;
    logic                  cfg_err;
    logic [c_DW-1:0]       fifo_data = '0;
    logic                  fifo_empty = 1'b0;
    logic                  fifo_pop;
    logic                  rd_page_valid;
    logic                  rd_release = 1'b0;
    logic [c_NB*c_AW-1:0]  rd_addr = '0;
    logic [c_NB*c_DW-1:0]  rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0, bad_pop = 0;
    int last_pop_cyc = 0, done_cyc = 0;
    int fifo_q = 0;
    bit starve = 1'b0;
    int p0, d0, e0, pa;

    input_fm_pingpong #(
        .AW(c_AW), .DW(c_DW), .NB(c_NB), .DEPTH(c_DEPTH), .SW(c_SW)
    ) dut (
        .clk(clk), .rst(rst), .syn_rst(syn_rst),
        .cfg_slice_size(cfg_slice_size), .cfg_slice_num(cfg_slice_num),
        .load_start(load_start), .load_ready(load_ready), .load_done(load_done),
        .cfg_err(cfg_err), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .rd_page_valid(rd_page_valid), .rd_release(rd_release),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: sample outputs mid-cycle, then feed the FIFO word for a pop.
    task automatic step();
        bit p;
        @(negedge clk);
        p = fifo_pop;
        if (fifo_pop) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            if (fifo_empty) bad_pop++;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cfg_err) err_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (p) begin
            fifo_data = fifo_q;
            fifo_q++;
        end
        if (starve) fifo_empty = ~fifo_empty;
    endtask

    task automatic start(input int size, input int num);
        cfg_slice_size = size[c_AW-1:0];
        cfg_slice_num  = num[c_SW-1:0];
        load_start     = 1'b1;
        step();
        load_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d;
        d = done_cnt;
        for (int k = 0; k < budget && done_cnt == d; k++) step();
        check(tag, done_cnt - d, 1);
    endtask

    task automatic release_page();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int bank, input int addr, input int exp);
        rd_addr = '0;
        rd_addr[bank*c_AW +: c_AW] = addr[c_AW-1:0];
        step();
        check(tag, rd_data[bank*c_DW +: c_DW], exp);
    endtask

    initial begin
        step();
        step();
        check("rst_load_ready", load_ready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_fifo_pop", fifo_pop, 0);
        check("rst_page_valid", rd_page_valid, 0);
        check("rst_rd_data", rd_data == '0, 1);
        rst = 1'b0;
        step();

        // Tile A into page 0
        fifo_q = 0; p0 = pop_cnt;
        start(16, 8);
        wait_done(400, "A_done");
        check("A_pops", pop_cnt - p0, 128);
        check("A_latency", done_cyc - last_pop_cyc, 2);
        check("A_page_valid", rd_page_valid, 1);
        check("A_load_ready", load_ready, 1);
        rd_chk("A_b0a0", 0, 0, 0);
        rd_chk("A_b0a16", 0, 16, 64);
        rd_chk("A_b3a31", 3, 31, 127);
        rd_chk("A_b2a5", 2, 5, 37);

        // Tile B into page 1 while page 0 is read
        fifo_q = 1000; p0 = pop_cnt;
        start(16, 8);
        rd_chk("AB_b0a16", 0, 16, 64);
        rd_chk("AB_b3a31", 3, 31, 127);
        wait_done(400, "B_done");
        check("B_pops", pop_cnt - p0, 128);
        check("B_full_ready", load_ready, 0);
        p0 = pop_cnt; d0 = done_cnt;
        start(16, 8);
        repeat (5) step();
        check("third_no_pops", pop_cnt - p0, 0);
        check("third_no_done", done_cnt - d0, 0);
        release_page();
        check("B_page_valid", rd_page_valid, 1);
        check("B_load_ready", load_ready, 1);
        rd_chk("B_b0a0", 0, 0, 1000);
        rd_chk("B_b3a31", 3, 31, 1127);

        // Tile C into page 0 with a starving FIFO
        fifo_q = 2000; p0 = pop_cnt; starve = 1'b1;
        start(16, 8);
        wait_done(800, "C_done");
        starve = 1'b0; fifo_empty = 1'b0;
        check("C_pops", pop_cnt - p0, 128);
        check("C_pop_when_empty", bad_pop, 0);
        release_page();
        rd_chk("C_b0a16", 0, 16, 2064);
        rd_chk("C_b1a20", 1, 20, 2084);
        rd_chk("C_b3a31", 3, 31, 2127);
        release_page();
        check("all_released", rd_page_valid, 0);

        // Capacity overflow: need 80 > 64
        e0 = err_cnt; p0 = pop_cnt; d0 = done_cnt;
        start(16, 17);
        step();
        step();
        check("cap_err", err_cnt - e0, 1);
        check("cap_no_pops", pop_cnt - p0, 0);
        check("cap_no_done", done_cnt - d0, 0);
        check("cap_ready", load_ready, 1);

        // Degenerate tile: zero slices
        p0 = pop_cnt;
        start(16, 0);
        wait_done(10, "zero_done");
        check("zero_pops", pop_cnt - p0, 0);
        check("zero_page_valid", rd_page_valid, 1);
        release_page();

        // Abort mid-load with syn_rst
        fifo_q = 3000; p0 = pop_cnt; d0 = done_cnt;
        start(16, 8);
        for (int k = 0; k < 200 && (pop_cnt - p0) < 50; k++) step();
        check("abort_pops", pop_cnt - p0, 50);
        syn_rst = 1'b1;
        step();
        syn_rst = 1'b0;
        #1;
        check("abort_pop", fifo_pop, 0);
        check("abort_ready", load_ready, 1);
        check("abort_valid", rd_page_valid, 0);
        pa = pop_cnt;
        repeat (20) step();
        check("abort_frozen", pop_cnt - pa, 0);
        check("abort_no_done", done_cnt - d0, 0);
        fifo_q = 4000;
        start(16, 8);
        wait_done(400, "D_done");
        rd_chk("D_b0a0", 0, 0, 4000);
        rd_chk("D_b0a16", 0, 16, 4064);
        rd_chk("D_b3a31", 3, 31, 4127);
        check("D_ready", load_ready, 1);

        // Asynchronous reset between edges during a load
        fifo_q = 5000;
        start(16, 8);
        repeat (20) step();
        check("pre_rst_pop", fifo_pop, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pop", fifo_pop, 0);
        check("arst_ready", load_ready, 1);
        check("arst_valid", rd_page_valid, 0);
        check("arst_done", load_done, 0);
        step();
        rst = 1'b0;
        release_page();
        step();
        check("arst_release_ignored", rd_page_valid, 0);
        fifo_q = 6000;
        start(4, 4);
        wait_done(100, "E_done");
        check("E_page_valid", rd_page_valid, 1);
        rd_chk("E_b1a0", 1, 0, 6004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
